// File: rtl/sobel_result_writer_pkg.sv
// Shared constants and encodings for the Sobel result writer.
// Frame geometry, derived pixel counts, RGB565 colours, state encodings.
// No logic; imported by the writer and its border address generator.
package sobel_result_writer_pkg;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 240;
   localparam int ADDR_W = 17;

   localparam int INTERIOR_PIXELS = (WIDTH - 2) * (HEIGHT - 2);
   localparam int BORDER_PIXELS   = 2 * WIDTH + 2 * (HEIGHT - 2);
   localparam int FRAME_PIXELS    = WIDTH * HEIGHT;

   // Counter widths: interior column index and accepted-pixel count
   localparam int X_W   = $clog2(WIDTH);
   localparam int CNT_W = $clog2(INTERIOR_PIXELS + 1);

   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB565_RED   = 16'hF800;
   localparam logic [15:0] RGB565_GREEN = 16'h07E0;
   localparam logic [15:0] RGB565_BLUE  = 16'h001F;
   localparam logic [15:0] BORDER_COLOR = RGB565_BLACK;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      BP_TOP    = 2'd0,
      BP_BOTTOM = 2'd1,
      BP_SIDE   = 2'd2
   } bphase_e;

endpackage

// File: rtl/sobel_border_addr_gen.sv
// Walks the 1-pixel frame border: top row, bottom row, then left/right pairs per row.
// addr_o is the address of the next border write; it moves one cycle after advance_i.
// No backpressure; the caller only advances when it actually issues a write.
module sobel_border_addr_gen
   import sobel_result_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   bphase_e           phase_q;
   logic [X_W-1:0]    cnt_q;     // column in TOP/BOTTOM, row in SIDE
   logic              right_q;   // SIDE: 0 = left column next, 1 = right column next
   logic [ADDR_W-1:0] addr_q;

   // Step through the border order; side addresses move by WIDTH-1 then by 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= BP_TOP;
         cnt_q   <= '0;
         right_q <= 1'b0;
         addr_q  <= '0;
      end else if (clear_i) begin
         phase_q <= BP_TOP;
         cnt_q   <= '0;
         right_q <= 1'b0;
         addr_q  <= '0;
      end else if (advance_i) begin
         case (phase_q)
            BP_TOP: begin
               if (cnt_q == X_W'(WIDTH - 1)) begin
                  phase_q <= BP_BOTTOM;
                  cnt_q   <= '0;
                  addr_q  <= ADDR_W'((HEIGHT - 1) * WIDTH);
               end else begin
                  cnt_q  <= cnt_q + X_W'(1);
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            BP_BOTTOM: begin
               if (cnt_q == X_W'(WIDTH - 1)) begin
                  phase_q <= BP_SIDE;
                  cnt_q   <= X_W'(1);
                  right_q <= 1'b0;
                  addr_q  <= ADDR_W'(WIDTH);
               end else begin
                  cnt_q  <= cnt_q + X_W'(1);
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            default: begin
               if (!right_q) begin
                  right_q <= 1'b1;
                  addr_q  <= addr_q + ADDR_W'(WIDTH - 1);
               end else begin
                  right_q <= 1'b0;
                  cnt_q   <= cnt_q + X_W'(1);
                  addr_q  <= addr_q + ADDR_W'(1);
               end
            end
         endcase
      end
   end

   assign addr_o = addr_q;
   assign last_o = (phase_q == BP_SIDE) && right_q && (cnt_q == X_W'(HEIGHT - 2));

endmodule

// File: rtl/sobel_result_writer.sv
// Writes the Sobel interior pixel stream plus a constant-colour border into the result frame buffer.
// Latency 1: a write issues the cycle after its pixel (or idle slot) is seen; frame_done one cycle after the final write.
// No backpressure: the stream always wins, border writes use idle cycles only, late pixels are dropped.
module sobel_result_writer
   import sobel_result_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [15:0]       in_data,
   input  logic              src_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              err_underrun,
   output logic              err_overflow
);

   state_e            state_q;
   logic [X_W-1:0]    x_q;
   logic [ADDR_W-1:0] iaddr_q;
   logic [CNT_W-1:0]  pix_cnt_q;
   logic              bdone_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              err_underrun_q;
   logic              err_overflow_q;

   logic              int_last;
   logic              abort;
   logic              border_clear;
   logic              border_adv;
   logic [ADDR_W-1:0] b_addr;
   logic              b_last;

   // A pixel arriving together with src_done that completes the interior is not an underrun
   assign int_last     = in_valid && (pix_cnt_q == CNT_W'(INTERIOR_PIXELS - 1));
   assign abort        = (state_q == ST_RUN) && src_done && !int_last;
   assign border_clear = (state_q == ST_IDLE) && start;
   assign border_adv   = ((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
                         !in_valid && !bdone_q && !abort;

   sobel_border_addr_gen u_border (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (border_clear),
      .advance_i (border_adv),
      .addr_o    (b_addr),
      .last_o    (b_last)
   );

   // Frame FSM with registered write port, status and error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         x_q            <= '0;
         iaddr_q        <= '0;
         pix_cnt_q      <= '0;
         bdone_q        <= 1'b0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         err_underrun_q <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         wr_en_q      <= 1'b0;
         frame_done_q <= 1'b0;

         if (border_adv) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= b_addr;
            wr_data_q <= BORDER_COLOR;
            if (b_last) bdone_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q        <= ST_RUN;
                  busy_q         <= 1'b1;
                  x_q            <= X_W'(1);
                  iaddr_q        <= ADDR_W'(WIDTH + 1);
                  pix_cnt_q      <= '0;
                  bdone_q        <= 1'b0;
                  err_underrun_q <= 1'b0;
                  err_overflow_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q        <= ST_IDLE;
                  busy_q         <= 1'b0;
                  err_underrun_q <= 1'b1;
               end else if (in_valid) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= iaddr_q;
                  wr_data_q <= in_data;
                  pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                  // Skip the right border of this row and the left border of the next
                  if (x_q == X_W'(WIDTH - 2)) begin
                     x_q     <= X_W'(1);
                     iaddr_q <= iaddr_q + ADDR_W'(3);
                  end else begin
                     x_q     <= x_q + X_W'(1);
                     iaddr_q <= iaddr_q + ADDR_W'(1);
                  end
                  if (int_last) state_q <= bdone_q ? ST_DONE : ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (in_valid) err_overflow_q <= 1'b1;
               if (border_adv && b_last) state_q <= ST_DONE;
            end
            default: begin
               if (in_valid) err_overflow_q <= 1'b1;
               frame_done_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign err_underrun = err_underrun_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_sobel_result_writer.sv
// Bench for sobel_result_writer: directed frame, underrun and reset scenarios.
// Expected writes are queued when stimulus is driven and matched as the DUT writes.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_sobel_result_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [15:0] in_data;
   logic        src_done;
   logic        wr_en;
   logic [16:0] wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        frame_done;
   logic        err_underrun;
   logic        err_overflow;

   sobel_result_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .src_done     (src_done),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_underrun (err_underrun),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          addr;
      logic [15:0] data;
   } wr_t;

   wr_t int_q[$];
   int  bord_q[$];
   bit  seen[76800];
   int  uniq, dups, wr_count, done_cnt, cyc, last_wr_cyc, last_wr_addr;
   int  tests, fails;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int border_addr(input int i);
      int k;
      if (i < 320) return i;
      if (i < 640) return 76480 + (i - 320);
      k = i - 640;
      return (1 + k / 2) * 320 + ((k % 2) != 0 ? 319 : 0);
   endfunction

   task automatic monitor();
      wr_t e;
      int  b;
      cyc++;
      if (wr_en === 1'b1) begin
         wr_count++;
         last_wr_cyc  = cyc;
         last_wr_addr = int'(wr_addr);
         if (int'(wr_addr) < 76800) begin
            if (seen[int'(wr_addr)]) dups++;
            else begin
               seen[int'(wr_addr)] = 1'b1;
               uniq++;
            end
         end
         if (wr_data == 16'h0000) begin
            check("border_write_expected", 32'(bord_q.size() > 0), 1);
            if (bord_q.size() > 0) begin
               b = bord_q.pop_front();
               check("border_addr", 32'(wr_addr), b);
            end
         end else begin
            check("interior_write_expected", 32'(int_q.size() > 0), 1);
            if (int_q.size() > 0) begin
               e = int_q.pop_front();
               check("interior_addr", 32'(wr_addr), e.addr);
               check("interior_data", 32'(wr_data), 32'(e.data));
            end
         end
      end
      if (frame_done === 1'b1) begin
         done_cnt++;
         check("done_after_last_write", cyc, last_wr_cyc + 1);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_sb();
      int_q.delete();
      bord_q.delete();
      for (int i = 0; i < 1116; i++) bord_q.push_back(border_addr(i));
   endtask

   task automatic send_pix(input int p);
      in_valid = 1'b1;
      in_data  = 16'($urandom) | 16'h0001;
      int_q.push_back('{(1 + p / 318) * 320 + 1 + p % 318, in_data});
      tick();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check({tag, "_wr_data"}, 32'(wr_data), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_frame_done"}, 32'(frame_done), 0);
      check({tag, "_err_underrun"}, 32'(err_underrun), 0);
      check({tag, "_err_overflow"}, 32'(err_overflow), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, w0, n, p;
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; src_done = 1'b0;
      tests = 0; fails = 0; uniq = 0; dups = 0; wr_count = 0; done_cnt = 0;
      cyc = 0; last_wr_cyc = -10; last_wr_addr = -1;

      // Reset state
      repeat (2) tick();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      tick();

      // Full frame: stream with an idle slot every 128 pixels, then one late pixel
      reset_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      p = 0;
      for (int i = 0; i < 75684; i++) begin
         if ((i % 128) == 127) begin
            in_valid = 1'b0;
            tick();
         end
         send_pix(i);
      end
      in_valid = 1'b1;
      in_data  = 16'h1234;
      tick();
      in_valid = 1'b0;
      check("overflow_set", 32'(err_overflow), 1);
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < 3000) begin
         tick();
         n++;
      end
      check("frame_done_seen", done_cnt - d0, 1);
      repeat (3) tick();
      check("frame_done_once", done_cnt - d0, 1);
      check("busy_low_after_done", 32'(busy), 0);
      check("interior_all_written", int_q.size(), 0);
      check("border_all_written", bord_q.size(), 0);
      check("unique_addresses", uniq, 76800);
      check("duplicate_writes", dups, 0);
      check("last_write_addr", last_wr_addr, 76479);
      check("no_underrun_full_frame", 32'(err_underrun), 0);
      check("overflow_sticky", 32'(err_overflow), 1);

      // Underrun: src_done after 1000 pixels
      reset_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("overflow_cleared_by_start", 32'(err_overflow), 0);
      check("busy_underrun_frame", 32'(busy), 1);
      for (int i = 0; i < 1000; i++) send_pix(i);
      in_valid = 1'b0;
      src_done = 1'b1;
      tick();
      src_done = 1'b0;
      check("underrun_set", 32'(err_underrun), 1);
      check("underrun_busy_low", 32'(busy), 0);
      w0 = wr_count;
      d0 = done_cnt;
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0];
         in_data  = 16'h00F0;
         tick();
      end
      in_valid = 1'b0;
      check("no_writes_after_abort", wr_count - w0, 0);
      check("no_done_after_abort", done_cnt - d0, 0);
      check("underrun_interior_drained", int_q.size(), 0);
      check("underrun_sticky", 32'(err_underrun), 1);
      check("idle_pixels_no_overflow", 32'(err_overflow), 0);

      // Reset in the middle of a frame, then a fresh frame
      reset_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 50; i++) send_pix(i);
      in_valid = 1'b0;
      tick();
      for (int i = 50; i < 60; i++) send_pix(i);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrun_reset");
      int_q.delete();
      bord_q.delete();
      in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      reset_sb();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      tick();
      check("restart_border_wr_en", 32'(wr_en), 1);
      check("restart_border_addr", 32'(wr_addr), 0);
      check("restart_border_data", 32'(wr_data), 0);
      send_pix(0);
      check("restart_first_interior_addr", 32'(wr_addr), 321);
      in_valid = 1'b0;
      src_done = 1'b1;
      tick();
      src_done = 1'b0;
      repeat (3) tick();
      check("restart_interior_drained", int_q.size(), 0);
      check("no_done_after_reset", done_cnt - d0, 0);
      check("restart_underrun", 32'(err_underrun), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sobel_result_writer.md
Name: sobel_result_writer

Overview:
- Downstream stage of the Sobel filter. Consumes the filter's real-time interior pixel stream and writes each pixel into the result frame buffer (RGB565, 320x240, 17-bit word address) at its raster position.
- Fills the 1-pixel image border with a constant colour, interleaved into idle cycles of the stream.
- Pulses frame_done once all 76800 locations are written, then the display path may read the buffer.

Parameters:
- WIDTH, 320, frame width in pixels
- HEIGHT, 240, frame height in pixels
- ADDR_W, 17, result buffer word-address width
- BORDER_COLOR, 16'h0000, RGB565 value written to border pixels

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, same cycle as the filter's start_process
- in_valid  in  1  filter pixel_valid; one interior pixel per high cycle
- in_data  in  16  filter pixel_data, RGB565
- src_done  in  1  filter process_done pulse
- wr_en  out  1  result buffer write strobe
- wr_addr  out  ADDR_W  result buffer write address
- wr_data  out  16  result buffer write data
- busy  out  1  high from accepted start until frame_done or abort
- frame_done  out  1  one-cycle pulse, frame complete and consistent
- err_underrun  out  1  sticky: src_done seen before all interior pixels arrived
- err_overflow  out  1  sticky: in_valid seen after the interior was complete

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs reset to 0. The FSM resets to IDLE. Reset mid-frame abandons the frame and asserts no frame_done.
- States:
  - IDLE: waits for start.
  - RUN: streams interior pixels and fills the border.
  - FLUSH: interior complete, finishing any remaining border pixels.
  - DONE: one cycle; drives frame_done, then returns to IDLE.
- IDLE -> RUN on start. Entering RUN clears the interior counters (x=1, y=1, addr=WIDTH+1), the border index, err_underrun and err_overflow.
- start while busy is ignored.
- Stream path: in_valid high in RUN gives wr_en=1, wr_addr=current interior addr, wr_data=in_data on the next cycle (latency 1, registered outputs).
  - Interior raster order: x runs 1..WIDTH-2 within a row, then y advances.
  - At x==WIDTH-2: x<=1, y<=y+1, addr<=addr+3. Otherwise addr<=addr+1.
  - Address arithmetic uses no multiplier.
- Border path: on RUN/FLUSH cycles with in_valid low and border not finished, write BORDER_COLOR at the next border address. in_valid always has priority, so border and stream writes never coincide.
- Border order, 2*WIDTH+2*(HEIGHT-2)=1116 writes total:
  - top row: 0..WIDTH-1
  - bottom row: (HEIGHT-1)*WIDTH..HEIGHT*WIDTH-1
  - then for y=1..HEIGHT-2: y*WIDTH and y*WIDTH+WIDTH-1
- The interior is complete after (WIDTH-2)*(HEIGHT-2)=75684 accepted pixels. When it is complete, RUN -> FLUSH, or RUN -> DONE if the border is also finished.
- FLUSH -> DONE when the last border write issues. frame_done is asserted the cycle after that last write. busy falls with frame_done.
- src_done in RUN before the interior is complete: set err_underrun and go to IDLE with no frame_done. busy drops; no further writes occur.
- src_done in FLUSH/DONE/IDLE is ignored.
- in_valid in FLUSH, DONE or IDLE: pixel dropped, no write. err_overflow is set only in FLUSH/DONE.
- Error flags hold until the next accepted start or reset.

Decomposition:
- Shared package holds:
  - WIDTH/HEIGHT/ADDR_W constants
  - derived INTERIOR_PIXELS=75684, BORDER_PIXELS=1116, FRAME_PIXELS=76800
  - RGB565 colour constants, including black and white
  - the state encoding
- One sub-module: sobel_border_addr_gen. It takes advance and clear, and outputs addr and last. It owns the border ordering and its row/column counters.

Test Plan:
- Start, then 75684 in_valid pulses with in_data=16'hFFFF spaced every 8 cycles -> interior addresses 321..76478 each written once with FFFF. First interior write at 321 and last at 76478. No write to x=0 or x=319. frame_done once; busy low after.
- Same run, checking border -> exactly 1116 writes of 16'h0000 covering 0..319, 76480..76799 and columns 0/319 for rows 1..238. Union of all writes is 76800 unique addresses.
- in_valid held high continuously for 75684 cycles -> zero border writes during the burst. All 1116 border writes occur in FLUSH. frame_done follows 1 cycle after address 319 of row 238 (76479) is written last.
- src_done after 1000 pixels -> err_underrun=1, busy=0, no frame_done, no further wr_en.
- Extra in_valid after pixel 75684 -> no write, err_overflow=1. A subsequent start clears it.
- rst_n low mid-RUN, then new start -> outputs 0 during reset. Next frame's first interior write is at 321, and the border index restarts at 0.
